// File: rtl/rv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rv_pkg
//  Description : Shared core definitions: data width, register address width
//                and the CLEAR/RUN controller state encoding reused by the
//                multi-cycle controllers of the core.
//  Revision    : 1.0  initial release
// ============================================================================
package rv_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } ctrl_state_t;

endpackage
`default_nettype wire

// File: rtl/reg_port_ctrl_starve_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : starve_cnt
//  Description : Saturating counter of blocked requester cycles. Produces a
//                single-cycle limit-reached pulse on the increment that
//                reaches LIMIT and returns to zero on that same edge.
//  Ports       : clk    - clock
//                rst    - asynchronous active-high reset
//                i_inc  - count this cycle
//                i_clr  - return count to zero
//                o_hit  - this increment reaches LIMIT (combinational)
//  Revision    : 1.0  initial release
// ============================================================================
module starve_cnt #(
    parameter int LIMIT = 4,
    parameter int CW    = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_inc,
    input  logic i_clr,
    output logic o_hit
);

    localparam logic [CW-1:0] c_limit_m1 = CW'(LIMIT - 1);

    logic [CW-1:0] r_cnt;
    logic          w_hit;

    // The increment that would make the count equal LIMIT is the hit, so the
    // counter itself never has to hold the value LIMIT.
    assign w_hit = i_inc && (r_cnt >= c_limit_m1);
    assign o_hit = w_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr || w_hit) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/reg_port_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : reg_port_ctrl
//  Description : Owner of the register-file write port. Zeroes x1..x31 after
//                reset or on clr_req, then arbitrates the port between the
//                core writeback (priority) and a valid/ready debug requester.
//                A starvation counter forces a one-cycle core stall so the
//                debug requester always gets through.
//  Ports       : clk, rst                   - clock, async active-high reset
//                core_we/core_rd/core_wdata - core writeback request
//                dbg_valid/dbg_rd/dbg_wdata - debug write request
//                dbg_ready                  - debug transfer accepted
//                clr_req                    - register-file clear pulse
//                RegWrite/Rd/Write_data     - reg_file write port
//                core_stall                 - core must hold off writes
//                init_done                  - clear sequence complete
//                drop_err                   - sticky: a core write was lost
//  Revision    : 1.0  initial release
// ============================================================================
module reg_port_ctrl
    import rv_pkg::*;
#(
    parameter int XLEN         = rv_pkg::XLEN,
    parameter int STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            core_we,
    input  logic [4:0]      core_rd,
    input  logic [XLEN-1:0] core_wdata,
    input  logic            dbg_valid,
    input  logic [4:0]      dbg_rd,
    input  logic [XLEN-1:0] dbg_wdata,
    output logic            dbg_ready,
    input  logic            clr_req,
    output logic            RegWrite,
    output logic [4:0]      Rd,
    output logic [XLEN-1:0] Write_data,
    output logic            core_stall,
    output logic            init_done,
    output logic            drop_err
);

    localparam logic [4:0] c_last_idx = 5'd31;

    ctrl_state_t     r_state;
    logic [4:0]      r_clr_idx;
    logic            r_stall_q;
    logic            r_core_stall;
    logic            r_init_done;
    logic            r_drop_err;

    logic            w_in_run;
    logic            w_core_own;
    logic            w_dbg_rdy;
    logic            w_dbg_own;
    logic [4:0]      w_sel_rd;
    logic [XLEN-1:0] w_sel_data;
    logic            w_next_clear;
    logic            w_blocked;
    logic            w_cnt_clr;
    logic            w_hit;
    logic            w_stall_next;
    logic            w_drop;

    // ------------------------------------------------------------------
    // Arbitration. dbg_ready is a function of state and core_we only, so
    // it never depends on dbg_valid.
    // ------------------------------------------------------------------
    assign w_in_run   = (r_state == ST_RUN);
    assign w_core_own = w_in_run && !r_stall_q && core_we;
    assign w_dbg_rdy  = w_in_run && (r_stall_q || !core_we);
    assign w_dbg_own  = w_dbg_rdy && dbg_valid;
    assign w_sel_rd   = w_core_own ? core_rd    : dbg_rd;
    assign w_sel_data = w_core_own ? core_wdata : dbg_wdata;

    // clr_req only matters in RUN; in CLEAR we leave after writing x31.
    assign w_next_clear = w_in_run ? clr_req : (r_clr_idx != c_last_idx);

    // A core write is lost whenever the port is not the core's to take.
    assign w_drop = core_we && (!w_in_run || r_stall_q);

    // ------------------------------------------------------------------
    // Starvation tracking
    // ------------------------------------------------------------------
    assign w_blocked = w_in_run && dbg_valid && !w_dbg_rdy;
    assign w_cnt_clr = w_dbg_own || !w_in_run || clr_req;

    starve_cnt #(
        .LIMIT (STARVE_LIMIT),
        .CW    (4)
    ) u_starve_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_inc (w_blocked),
        .i_clr (w_cnt_clr),
        .o_hit (w_hit)
    );

    // A forced stall is pointless if a clear is about to start.
    assign w_stall_next = w_hit && !w_next_clear;

    // ------------------------------------------------------------------
    // Write port: combinational from registered state and current inputs;
    // held quiet while reset is asserted.
    // ------------------------------------------------------------------
    always_comb begin
        RegWrite   = 1'b0;
        Rd         = '0;
        Write_data = '0;
        dbg_ready  = 1'b0;
        if (!rst) begin
            if (!w_in_run) begin
                RegWrite = 1'b1;
                Rd       = r_clr_idx;
            end else begin
                dbg_ready  = w_dbg_rdy;
                Rd         = w_sel_rd;
                Write_data = w_sel_data;
                RegWrite   = (w_core_own || w_dbg_own) && (w_sel_rd != '0);
            end
        end
    end

    // ------------------------------------------------------------------
    // Controller state and registered status outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_CLEAR;
            r_clr_idx    <= 5'd1;
            r_stall_q    <= 1'b0;
            r_core_stall <= 1'b1;
            r_init_done  <= 1'b0;
            r_drop_err   <= 1'b0;
        end else begin
            r_state      <= w_next_clear ? ST_CLEAR : ST_RUN;
            // Index advances only while a clear continues; every other
            // path re-arms it at x1 for the next clear.
            r_clr_idx    <= (!w_in_run && w_next_clear) ? r_clr_idx + 1'b1 : 5'd1;
            r_stall_q    <= w_stall_next;
            r_core_stall <= w_next_clear || w_stall_next;
            r_init_done  <= !w_next_clear;
            r_drop_err   <= r_drop_err || w_drop;
        end
    end

    assign core_stall = r_core_stall;
    assign init_done  = r_init_done;
    assign drop_err   = r_drop_err;

endmodule
`default_nettype wire

// File: tb/tb_reg_port_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_reg_port_ctrl
//  Description : Self-checking bench for reg_port_ctrl. Directed scenarios
//                plus a randomized run against a behavioural model; a simple
//                register array stands in for reg_file to check readback.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_reg_port_ctrl;

    localparam int XLEN = 32;
    localparam int LIM  = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            core_we;
    logic [4:0]      core_rd;
    logic [XLEN-1:0] core_wdata;
    logic            dbg_valid;
    logic [4:0]      dbg_rd;
    logic [XLEN-1:0] dbg_wdata;
    logic            dbg_ready;
    logic            clr_req;
    logic            RegWrite;
    logic [4:0]      Rd;
    logic [XLEN-1:0] Write_data;
    logic            core_stall;
    logic            init_done;
    logic            drop_err;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    reg_port_ctrl #(.XLEN(XLEN), .STARVE_LIMIT(LIM)) dut (
        .clk(clk), .rst(rst),
        .core_we(core_we), .core_rd(core_rd), .core_wdata(core_wdata),
        .dbg_valid(dbg_valid), .dbg_rd(dbg_rd), .dbg_wdata(dbg_wdata),
        .dbg_ready(dbg_ready), .clr_req(clr_req),
        .RegWrite(RegWrite), .Rd(Rd), .Write_data(Write_data),
        .core_stall(core_stall), .init_done(init_done), .drop_err(drop_err)
    );

    // Stand-in register file: captures the write port, x0 hardwired to 0.
    logic [XLEN-1:0] rf [32];
    always @(posedge clk) if (RegWrite && Rd != 5'd0) rf[Rd] <= Write_data;

    function automatic logic [XLEN-1:0] rf_rd(input int a);
        return (a == 0) ? '0 : rf[a];
    endfunction

    // ---------------- behavioural reference model ----------------
    bit              m_clearing;
    int              m_idx;
    int              m_blocked;
    bit              m_forced;
    bit              m_drop;
    logic [XLEN-1:0] m_rf [32];
    bit              e_we, e_ready, e_stall, e_init;
    logic [4:0]      e_rd;
    logic [XLEN-1:0] e_data;

    function automatic void model_reset();
        m_clearing = 1; m_idx = 1; m_blocked = 0; m_forced = 0; m_drop = 0;
        e_stall = 1; e_init = 0;
    endfunction

    // Who owns the port this cycle, from the current inputs.
    function automatic void model_eval();
        bit core_owns, dbg_owns;
        e_we = 0; e_rd = 0; e_data = 0; e_ready = 0;
        if (m_clearing) begin
            e_we = 1; e_rd = 5'(m_idx); e_data = 0;
        end else begin
            core_owns = !m_forced && core_we;
            e_ready   = !core_owns;
            dbg_owns  = e_ready && dbg_valid;
            if (core_owns) begin e_rd = core_rd; e_data = core_wdata; end
            else if (dbg_owns) begin e_rd = dbg_rd; e_data = dbg_wdata; end
            e_we = (core_owns || dbg_owns) && (e_rd != 0);
        end
    endfunction

    function automatic void model_commit();
        bit acc;
        acc = e_ready && dbg_valid;
        if (core_we && (m_clearing || m_forced)) m_drop = 1;
        if (e_we) m_rf[e_rd] = e_data;
        if (m_clearing) begin
            m_forced = 0; m_blocked = 0;
            if (m_idx == 31) begin m_clearing = 0; m_idx = 1; end
            else m_idx++;
        end else begin
            m_forced = 0;
            if (acc) m_blocked = 0;
            else if (dbg_valid) begin
                m_blocked++;
                if (m_blocked == LIM) begin m_forced = 1; m_blocked = 0; end
            end
            if (clr_req) begin m_clearing = 1; m_idx = 1; m_blocked = 0; m_forced = 0; end
        end
        e_stall = m_clearing || m_forced;
        e_init  = !m_clearing;
    endfunction

    // Cycle phases: inputs are set at posedge+1, checked at posedge+5.
    task automatic idle_inputs();
        core_we = 0; core_rd = 0; core_wdata = 0;
        dbg_valid = 0; dbg_rd = 0; dbg_wdata = 0; clr_req = 0;
    endtask

    task automatic half();
        model_eval();
        #4;
    endtask

    task automatic finish_cycle();
        @(posedge clk);
        model_commit();
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #3;
        n_tests++;
        if (RegWrite !== 1'b0 || Rd !== 5'd0 || Write_data !== '0 || dbg_ready !== 1'b0 ||
            core_stall !== 1'b1 || init_done !== 1'b0 || drop_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got we=%b rd=%0d wd=%h rdy=%b stall=%b init=%b drop=%b, want 0 0 0 0 1 0 0",
                     RegWrite, Rd, Write_data, dbg_ready, core_stall, init_done, drop_err);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 1; i <= 31; i++) begin
            half();
            n_tests++;
            if (RegWrite !== 1'b1 || Rd !== 5'(i) || Write_data !== '0 || dbg_ready !== 1'b0 ||
                core_stall !== 1'b1 || init_done !== 1'b0) begin
                n_fail++;
                $display("FAIL clear_seq[%0d]: got we=%b rd=%0d wd=%h rdy=%b stall=%b init=%b, want we=1 rd=%0d wd=0 rdy=0 stall=1 init=0",
                         i, RegWrite, Rd, Write_data, dbg_ready, core_stall, init_done, i);
            end
            finish_cycle();
        end
        half();
        n_tests++;
        if (init_done !== 1'b1 || core_stall !== 1'b0 || rf_rd(5) !== 32'h0) begin
            n_fail++;
            $display("FAIL after_clear: got init=%b stall=%b x5=%h, want init=1 stall=0 x5=00000000",
                     init_done, core_stall, rf_rd(5));
        end
        finish_cycle();
    endtask

    task automatic test_core_dbg_conflict();
        core_we = 1; core_rd = 5; core_wdata = 32'hDEADBEEF;
        dbg_valid = 1; dbg_rd = 10; dbg_wdata = 32'h12345678;
        half();
        n_tests++;
        if (RegWrite !== 1'b1 || Rd !== 5'd5 || Write_data !== 32'hDEADBEEF || dbg_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL conflict_core: got we=%b rd=%0d wd=%h rdy=%b, want we=1 rd=5 wd=deadbeef rdy=0",
                     RegWrite, Rd, Write_data, dbg_ready);
        end
        finish_cycle();
        core_we = 0;
        half();
        n_tests++;
        if (RegWrite !== 1'b1 || Rd !== 5'd10 || Write_data !== 32'h12345678 || dbg_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL conflict_dbg: got we=%b rd=%0d wd=%h rdy=%b, want we=1 rd=10 wd=12345678 rdy=1",
                     RegWrite, Rd, Write_data, dbg_ready);
        end
        finish_cycle();
        dbg_valid = 0;
        n_tests++;
        if (rf_rd(5) !== 32'hDEADBEEF || rf_rd(10) !== 32'h12345678) begin
            n_fail++;
            $display("FAIL conflict_readback: got x5=%h x10=%h, want deadbeef 12345678", rf_rd(5), rf_rd(10));
        end
    endtask

    task automatic test_starve();
        dbg_valid = 1; dbg_rd = 3; dbg_wdata = 32'hC0FFEE01;
        core_we = 1;
        for (int k = 0; k < LIM; k++) begin
            core_rd = 5'(8 + k); core_wdata = $urandom;
            half();
            n_tests++;
            if (dbg_ready !== 1'b0 || RegWrite !== 1'b1 || Rd !== 5'(8 + k)) begin
                n_fail++;
                $display("FAIL starve_blocked[%0d]: got rdy=%b we=%b rd=%0d, want rdy=0 we=1 rd=%0d",
                         k, dbg_ready, RegWrite, Rd, 8 + k);
            end
            finish_cycle();
        end
        n_tests++;
        if (core_stall !== 1'b1 || drop_err !== 1'b0) begin
            n_fail++;
            $display("FAIL starve_stall: got stall=%b drop=%b, want stall=1 drop=0", core_stall, drop_err);
        end
        core_rd = 20; core_wdata = 32'hBAD0BAD0;
        half();
        n_tests++;
        if (dbg_ready !== 1'b1 || RegWrite !== 1'b1 || Rd !== 5'd3 || Write_data !== 32'hC0FFEE01) begin
            n_fail++;
            $display("FAIL starve_dbg_lands: got rdy=%b we=%b rd=%0d wd=%h, want rdy=1 we=1 rd=3 wd=c0ffee01",
                     dbg_ready, RegWrite, Rd, Write_data);
        end
        finish_cycle();
        dbg_valid = 0; core_we = 0;
        n_tests++;
        if (drop_err !== 1'b1 || core_stall !== 1'b0 || rf_rd(3) !== 32'hC0FFEE01 || rf_rd(20) !== 32'h0) begin
            n_fail++;
            $display("FAIL starve_after: got drop=%b stall=%b x3=%h x20=%h, want drop=1 stall=0 x3=c0ffee01 x20=00000000",
                     drop_err, core_stall, rf_rd(3), rf_rd(20));
        end
    endtask

    task automatic test_dbg_x0();
        dbg_valid = 1; dbg_rd = 0; dbg_wdata = 32'hFFFFFFFF; core_we = 0;
        half();
        n_tests++;
        if (dbg_ready !== 1'b1 || RegWrite !== 1'b0) begin
            n_fail++;
            $display("FAIL dbg_x0: got rdy=%b we=%b, want rdy=1 we=0", dbg_ready, RegWrite);
        end
        finish_cycle();
        dbg_valid = 0;
    endtask

    task automatic test_clear_req();
        core_we = 1; core_rd = 7; core_wdata = 32'hA5A5A5A5;
        half(); finish_cycle();
        core_we = 0;
        n_tests++;
        if (rf_rd(7) !== 32'hA5A5A5A5) begin
            n_fail++;
            $display("FAIL clr_pre_x7: got %h, want a5a5a5a5", rf_rd(7));
        end
        clr_req = 1; dbg_valid = 1; dbg_rd = 9; dbg_wdata = 32'h99990009;
        half();
        n_tests++;
        if (RegWrite !== 1'b1 || Rd !== 5'd9 || dbg_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL clr_req_cycle: got we=%b rd=%0d rdy=%b, want we=1 rd=9 rdy=1", RegWrite, Rd, dbg_ready);
        end
        finish_cycle();
        clr_req = 0; dbg_valid = 0;
        for (int i = 1; i <= 31; i++) begin
            half();
            n_tests++;
            if (RegWrite !== 1'b1 || Rd !== 5'(i) || Write_data !== '0 || init_done !== 1'b0 || core_stall !== 1'b1) begin
                n_fail++;
                $display("FAIL clr_seq[%0d]: got we=%b rd=%0d wd=%h init=%b stall=%b, want we=1 rd=%0d wd=0 init=0 stall=1",
                         i, RegWrite, Rd, Write_data, init_done, core_stall, i);
            end
            finish_cycle();
        end
        n_tests++;
        if (init_done !== 1'b1 || rf_rd(7) !== 32'h0 || rf_rd(9) !== 32'h0) begin
            n_fail++;
            $display("FAIL clr_done: got init=%b x7=%h x9=%h, want init=1 x7=0 x9=0", init_done, rf_rd(7), rf_rd(9));
        end
    endtask

    task automatic test_reset_midclear();
        clr_req = 1;
        half(); finish_cycle();
        clr_req = 0;
        for (int i = 1; i <= 11; i++) begin half(); finish_cycle(); end
        half();
        n_tests++;
        if (Rd !== 5'd12 || RegWrite !== 1'b1) begin
            n_fail++;
            $display("FAIL midclear_idx: got rd=%0d we=%b, want rd=12 we=1", Rd, RegWrite);
        end
        rst = 1'b1;
        model_reset();
        #2;
        n_tests++;
        if (RegWrite !== 1'b0 || Rd !== 5'd0 || dbg_ready !== 1'b0 || core_stall !== 1'b1 ||
            init_done !== 1'b0 || drop_err !== 1'b0) begin
            n_fail++;
            $display("FAIL midclear_reset: got we=%b rd=%0d rdy=%b stall=%b init=%b drop=%b, want 0 0 0 1 0 0",
                     RegWrite, Rd, dbg_ready, core_stall, init_done, drop_err);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 1; i <= 31; i++) begin
            half();
            n_tests++;
            if (RegWrite !== 1'b1 || Rd !== 5'(i) || init_done !== 1'b0) begin
                n_fail++;
                $display("FAIL restart_seq[%0d]: got we=%b rd=%0d init=%b, want we=1 rd=%0d init=0",
                         i, RegWrite, Rd, init_done, i);
            end
            finish_cycle();
        end
        n_tests++;
        if (init_done !== 1'b1 || core_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL restart_done: got init=%b stall=%b, want init=1 stall=0", init_done, core_stall);
        end
    endtask

    task automatic test_random();
        bit pend = 0;
        for (int c = 0; c < 600; c++) begin
            core_we    = e_stall ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
            core_rd    = 5'($urandom);
            core_wdata = $urandom;
            if (!pend && $urandom_range(0, 2) == 0) begin
                pend = 1; dbg_rd = 5'($urandom); dbg_wdata = $urandom;
            end
            dbg_valid = pend;
            clr_req   = ($urandom_range(0, 149) == 0);
            half();
            n_tests++;
            if (RegWrite !== e_we || dbg_ready !== e_ready || (e_we && (Rd !== e_rd || Write_data !== e_data)) ||
                core_stall !== e_stall || init_done !== e_init || drop_err !== m_drop) begin
                n_fail++;
                $display("FAIL random[%0d]: got we=%b rd=%0d wd=%h rdy=%b stall=%b init=%b drop=%b, want we=%b rd=%0d wd=%h rdy=%b stall=%b init=%b drop=%b",
                         c, RegWrite, Rd, Write_data, dbg_ready, core_stall, init_done, drop_err,
                         e_we, e_rd, e_data, e_ready, e_stall, e_init, m_drop);
            end
            if (pend && e_ready) pend = 0;
            finish_cycle();
        end
        idle_inputs();
        for (int r = 1; r < 32; r++) begin
            n_tests++;
            if (rf_rd(r) !== m_rf[r]) begin
                n_fail++;
                $display("FAIL random_rf[x%0d]: got %h, want %h", r, rf_rd(r), m_rf[r]);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_core_dbg_conflict();
        test_starve();
        test_dbg_x0();
        test_clear_req();
        test_reset_midclear();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/reg_port_ctrl.md
# reg_port_ctrl

Write-port controller for the 32×32 register file (`reg_file`). It owns the register file's single write port (`RegWrite`, `Rd`, `Write_data`) and zeroes x1..x31 after reset or on request. It shares the port between the core writeback stage, which has priority, and a debug/loader requester using a valid/ready handshake. A starvation counter guarantees the debug requester eventual access by stalling the core.

## Interface
- `XLEN`, default 32: data width.
- `STARVE_LIMIT`, default 4: consecutive blocked debug cycles before a forced core stall; legal range 1..15.
- `clk` in, 1 bit: clock. All state updates on the rising edge.
- `rst` in, 1 bit: reset, asynchronous, active-high.
- `core_we` in, 1 bit: core writeback request this cycle.
- `core_rd` in, 5 bits: core destination register.
- `core_wdata` in, XLEN bits: core write data.
- `dbg_valid` in, 1 bit: debug write request.
- `dbg_rd` in, 5 bits: debug destination register.
- `dbg_wdata` in, XLEN bits: debug write data.
- `dbg_ready` out, 1 bit: debug request accepted this cycle.
- `clr_req` in, 1 bit: single-cycle pulse requesting a register-file clear.
- `RegWrite` out, 1 bit: write enable to `reg_file`.
- `Rd` out, 5 bits: write address to `reg_file`.
- `Write_data` out, XLEN bits: write data to `reg_file`.
- `core_stall` out, 1 bit: the core must not assert `core_we` next cycle while this is high.
- `init_done` out, 1 bit: high once the clear sequence has completed.
- `drop_err` out, 1 bit: sticky flag; a core write was dropped.

## Operation
- FSM states:
  - CLEAR: sequential zeroing of the register file.
  - RUN: normal arbitration.
- Reset entry:
  - Reset forces CLEAR with `clr_idx`=1, `stall_q`=0, starve count 0, `drop_err`=0.
  - During reset, outputs are: `RegWrite`=0, `Rd`=0, `Write_data`=0, `dbg_ready`=0, `core_stall`=1, `init_done`=0.
- CLEAR state:
  - Each cycle drives `RegWrite`=1, `Rd`=`clr_idx`, `Write_data`=0, then increments `clr_idx`.
  - When `clr_idx`==31 is written, the next state is RUN.
  - A full clear takes exactly 31 cycles; x0 is never written.
  - `core_stall`=1, `dbg_ready`=0, `init_done`=0 throughout; `clr_req` is ignored.
- RUN state, normal cycle (`stall_q`=0):
  - If `core_we`=1, the core owns the port: `Rd`=`core_rd`, `Write_data`=`core_wdata`, `dbg_ready`=0.
  - Otherwise `dbg_ready`=1 and, if `dbg_valid`=1, the debug request owns the port.
- RUN state, forced-stall cycle (`stall_q`=1):
  - The debug request owns the port and `dbg_ready`=1.
  - If `core_we`=1 in this cycle, the core write is dropped and `drop_err` is set.
- `RegWrite` in RUN equals (an owner exists) && (selected rd ≠ 0). A debug write to x0 still completes its handshake, with `RegWrite`=0.
- Starvation counter:
  - Increments when `dbg_valid`=1 && `dbg_ready`=0; clears on any accepted debug transfer.
  - When the count reaches `STARVE_LIMIT`, `stall_q` is set for exactly one cycle and the counter clears.
- `clr_req`=1 in RUN:
  - The current cycle's arbitration completes normally.
  - The next state is CLEAR with `clr_idx`=1 and `init_done` dropping to 0.
  - A pending debug request stays pending; `dbg_valid` must be held.
- `drop_err` is also set if `core_we`=1 in any CLEAR cycle. It clears only on reset.

## Timing
- Write latency is zero: the outputs to `reg_file` are combinational from the registered state and current inputs. The register file captures them on the same rising edge.
- Debug handshake:
  - A transfer occurs on the edge where `dbg_valid`=1 and `dbg_ready`=1.
  - `dbg_rd`/`dbg_wdata` must be stable while `dbg_valid`=1.
  - `dbg_ready` never depends combinationally on `dbg_valid`.
- `core_stall` = (state==CLEAR) || `stall_q_next`, and is registered.
- After `rst` falls, `init_done` rises on the edge following the 31st clear write.
- Worst-case debug wait in RUN is `STARVE_LIMIT`+1 cycles.
- Asserting reset mid-clear or mid-handshake aborts immediately. The clear restarts from x1, and an untransferred debug request is not lost provided `dbg_valid` is held.

## Structure
- A shared package `rv_pkg` holds `XLEN`, the register address width (5), and the FSM state enum (CLEAR, RUN). The enum is reused by later multi-cycle controllers.
- One sub-module is natural: `starve_cnt`, a saturating counter with clear and a limit-reached pulse. Everything else is inline.
- `reg_file` is instantiated by the parent, not inside this block.

## Test plan
- Reset, then release: the bench observes 31 writes of 0 to x1..x31 in order, then `init_done`=1 and `core_stall`=0. Reading `reg_file` x5 returns 00000000.
- Core writes x5=DEADBEEF at the same time as a debug write of x10=12345678:
  - cycle 1 writes x5 with `dbg_ready`=0;
  - the next idle cycle writes x10.
  - Readback gives x5=deadbeef and x10=12345678.
- `core_we` held high continuously with `dbg_valid` high: after 4 blocked cycles `core_stall`=1, then the debug write lands in the stall cycle. A core write in that cycle sets `drop_err`=1.
- Debug write x0=FFFFFFFF: the handshake completes, `RegWrite`=0, and x0 still reads 00000000.
- `clr_req` pulse after x7=A5A5A5A5: 31 clear cycles follow, then x7 reads 00000000 and `init_done` returns to 1.
- Assert `rst` at clear index 12: the sequence restarts at x1 after release, and the total clear length is again 31 cycles.
